// File: rtl/tmc2130_spi_if.sv
// SPI pin bundle between a TMC2130-style initiator (master) and the register responder (slave).
interface tmc2130_spi_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic step;
  logic miso;

  modport master (output sclk, cs_n, mosi, step, input miso);
  modport slave  (input sclk, cs_n, mosi, step, output miso);
endinterface

// File: rtl/tmc2130_spi_responder.sv
// SPI mode-3 responder mimicking the TMC2130 40-bit datagram register interface.
// Optional step counter / standstill detection enabled by defining TMC_SPI_RESP_STEPCNT_EN.
module tmc2130_spi_responder #(
  parameter int NUM_REGS          = 16,
  parameter int STANDSTILL_CYCLES = 1048576
) (
  input  logic         clk_in,
  input  logic         reset_n_in,
  tmc2130_spi_if.slave spi,
  output logic         wr_strobe_out,
  output logic [6:0]   wr_addr_out,
  output logic [31:0]  wr_data_out,
  output logic         frame_err_out
);
  localparam int         AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREG8     = 8'(NUM_REGS);
  localparam logic [6:0] STEP_ADDR = 7'h6A;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_nxt;

  // sync[i][0] first FF, [1] second, [2] edge-detect reference; i: 0 sclk, 1 cs_n, 2 mosi, 3 step
  logic [3:0][2:0] sync;
  logic [3:0]      pins;
  assign pins = {spi.step, spi.mosi, spi.cs_n, spi.sclk};

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) sync <= '0;
    else for (int i = 0; i < 4; i++) sync[i] <= {sync[i][1:0], pins[i]};
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, step_rise;
  assign sclk_rise =  sync[0][1] & ~sync[0][2];
  assign sclk_fall = ~sync[0][1] &  sync[0][2];
  assign cs_rise   =  sync[1][1] & ~sync[1][2];
  assign cs_fall   = ~sync[1][1] &  sync[1][2];
  assign mosi_s    =  sync[2][1];
  assign step_rise =  sync[3][1] & ~sync[3][2];

  logic        standstill;
  logic [31:0] step_val;

`ifdef TMC_SPI_RESP_STEPCNT_EN
  localparam int IW = $clog2(STANDSTILL_CYCLES + 1);
  logic [9:0]    step_cnt;
  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      step_cnt <= '0;
      idle_cnt <= '0;
    end else if (step_rise) begin
      step_cnt <= step_cnt + 10'd1;
      idle_cnt <= '0;
    end else if (idle_cnt != IW'(STANDSTILL_CYCLES)) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign standstill = (idle_cnt == IW'(STANDSTILL_CYCLES));
  assign step_val   = {22'd0, step_cnt};
`else
  logic unused_step;
  assign unused_step = step_rise;
  assign standstill  = 1'b0;
  assign step_val    = '0;
`endif

  logic [31:0] regs [NUM_REGS];
  logic [39:0] rx_shift, tx_shift;
  logic [31:0] rd_latch, rd_val;
  logic [5:0]  bit_cnt;
  logic        miso, pend, reset_flag;
  logic [7:0]  status;
  assign status   = {4'b0, standstill, 2'b0, reset_flag};
  assign spi.miso = miso;

  logic        rx_wr, mapped, wr_ok;
  logic [6:0]  rx_addr;
  logic [31:0] rx_data;
  logic [AW-1:0] idx;
  assign rx_wr   = rx_shift[39];
  assign rx_addr = rx_shift[38:32];
  assign rx_data = rx_shift[31:0];
  assign idx     = rx_addr[AW-1:0];
  assign mapped  = ({1'b0, rx_addr} < NREG8) && (rx_addr != STEP_ADDR);
  assign wr_ok   = rx_wr && mapped;

  logic unused_bits;
  assign unused_bits = ^{sync[2][2], tx_shift[39]};

  // Read-back reflects the register contents after this datagram's own write
  always_comb begin
    rd_val = '0;
    if (rx_addr == STEP_ADDR) rd_val = step_val;
    else if (mapped)          rd_val = wr_ok ? rx_data : regs[idx];
  end

  logic start, commit_ok, commit_bad;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    case (state)
      IDLE: if (cs_fall || pend) begin
        state_nxt = SHIFT;
        start     = 1'b1;
      end
      SHIFT: if (cs_rise) state_nxt = COMMIT;
      COMMIT: begin
        state_nxt = IDLE;
        if (bit_cnt == 6'd40) commit_ok  = 1'b1;
        else                  commit_bad = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      rd_latch      <= '0;
      bit_cnt       <= '0;
      miso          <= 1'b0;
      pend          <= 1'b0;
      reset_flag    <= 1'b1;
      wr_strobe_out <= 1'b0;
      wr_addr_out   <= '0;
      wr_data_out   <= '0;
      frame_err_out <= 1'b0;
    end else begin
      wr_strobe_out <= 1'b0;
      frame_err_out <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          miso    <= 1'b0;
          if (start) begin
            tx_shift <= {status, rd_latch};
            miso     <= status[7];
            pend     <= 1'b0;
          end
        end
        SHIFT: begin
          // cs_n rising takes priority over any SCK edge seen in the same cycle
          if (cs_rise) miso <= 1'b0;
          else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[38:0], mosi_s};
              if (bit_cnt != 6'd41) bit_cnt <= bit_cnt + 6'd1;
            end
            if (sclk_fall && bit_cnt != 6'd0) begin
              tx_shift <= {tx_shift[38:0], 1'b0};
              miso     <= tx_shift[38];
            end
          end
        end
        COMMIT: begin
          miso <= 1'b0;
          if (cs_fall) pend <= 1'b1;
          if (commit_ok) begin
            if (wr_ok) begin
              regs[idx]     <= rx_data;
              wr_strobe_out <= 1'b1;
              wr_addr_out   <= rx_addr;
              wr_data_out   <= rx_data;
            end
            rd_latch   <= rd_val;
            reset_flag <= 1'b0;
          end
          if (commit_bad) frame_err_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
